fpu_mmio_regs: RTL and testbench
================================

Name: fpu_mmio_regs

Overview:
Memory-mapped register front-end for the pipelined FPU on the DE0-Nano data bus. Decodes the FPU window (A, B, CMD, RESULT, STATUS, CTRL), holds operands, issues one-cycle start pulses to the FPU core and waits for its valid strobe. Captures result and flags, and exposes busy/done/error status plus an optional interrupt. Sits between the processor/bench data-memory bus and the FPU datapath.

Parameters:
BASE_ADDR, 13'h0600, byte address of register 0; word-aligned; window is BASE_ADDR..BASE_ADDR+0x14
FPU_LATENCY, 4, nominal cycles from fpu_start to fpu_valid; sets timeout
TIMEOUT_SLACK, 8, extra cycles beyond FPU_LATENCY before error is declared

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_write  in  1  bus write enable
data_adr  in  13  bus byte address
write_data  in  32  bus write data
read_data  out  32  bus read data, combinational from registers; 0 when not hit
hit  out  1  data_adr falls inside the window (for upstream read mux)
fpu_a  out  32  operand A register
fpu_b  out  32  operand B register
fpu_op  out  2  opcode latched at GO
fpu_start  out  1  one-cycle issue pulse
fpu_valid  in  1  FPU result valid strobe
fpu_result  in  32  FPU result
fpu_flags  in  5  FPU exception flags (NV,DZ,OF,UF,NX)
busy  out  1  operation in flight
irq  out  1  done & irq_en, level

Behaviour:
- Register map (offset from BASE_ADDR): 0x00 A rw; 0x04 B rw; 0x08 CMD wo (bit0 GO, bits[2:1] op; reads 0); 0x0C RESULT ro; 0x10 STATUS ro {23'b0, flags[4:0], overrun, error, done, busy}; 0x14 CTRL rw bit0 irq_en.
- Address match uses data_adr[12:2]; data_adr[1:0] ignored. Unmapped offsets inside the window (0x18, 0x1C) are ignored on write and read 0.
- Reset (async, reset_n=0): A, B, RESULT, flags, op, irq_en = 0; FSM=IDLE; fpu_start=0, busy=0, done=0, error=0, overrun=0, irq=0.
- FSM states:
  - IDLE: a CMD write with GO=1 latches op, clears done, error and flags, asserts fpu_start next cycle, and moves to ISSUE. GO=0 writes have no effect.
  - ISSUE: fpu_start=1 for exactly one cycle; load the timeout counter with FPU_LATENCY+TIMEOUT_SLACK; go to WAIT.
  - WAIT: on fpu_valid, capture fpu_result into RESULT and fpu_flags into flags; set done; go to IDLE. Otherwise decrement the counter. When it reaches 0, set error, leave RESULT unchanged, and go to IDLE.
- busy=1 in ISSUE and WAIT. fpu_valid arriving in IDLE or ISSUE is ignored.
- Writes to A or B while busy are ignored and set overrun. A CMD GO while busy is ignored and sets overrun. overrun clears on a STATUS read or on an accepted GO.
- Reading RESULT (mem_write=0, address hit) clears done on the next edge. A simultaneous fpu_valid wins: done is set.
- Write and GO in the same cycle are impossible (one address per cycle). A and B written before GO are used: fpu_a and fpu_b are the live registers and must stay stable while busy.
- Latency: CMD write at edge N → fpu_start high in cycle N+1 → with FPU_LATENCY=1, RESULT is readable from edge N+3.
- irq = done & irq_en, registered.

Test Plan:
- Reset mid-WAIT: write A=10, B=20, GO; assert reset_n=0 two cycles later → busy=0, done=0, RESULT=0 immediately (asynchronous); a late fpu_valid is ignored.
- Nominal add: write A=0x41200000 (10.0), B=0x41A00000 (20.0), CMD=0x1; model fpu_valid after 4 cycles with 0x41F00000 → fpu_start is a single-cycle pulse, RESULT=0x41F00000, STATUS=0x2, busy dropped.
- Flags/irq: CTRL=1; GO op=2 with model flags=5'b01000 → STATUS[8:4]=01000, irq=1; reading RESULT → done=0, irq=0.
- Overrun: GO, then write A=7 and GO again while busy → A keeps its old value, only one fpu_start, STATUS bit3=1; reading STATUS clears it.
- Timeout: GO with the model never asserting valid → after 1+FPU_LATENCY+TIMEOUT_SLACK cycles, STATUS=0x4 and busy=0; the next GO clears error.
- Decode: read offset 0x18, an address outside the window, and CMD → read_data=0; hit=0 outside the window; a write to 0x0608 with data_adr[1:0]=2'b11 still acts as CMD.

Source files
------------

// File: rtl/fpu_mmio_regs_if.sv
// rtl/fpu_mmio_regs_if.sv - data-memory bus bundle for the FPU register window
interface fpu_mmio_regs_if;
  logic        mem_write;
  logic [12:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output mem_write,
    output data_adr,
    output write_data,
    input  read_data,
    input  hit
  );

  modport slave (
    input  mem_write,
    input  data_adr,
    input  write_data,
    output read_data,
    output hit
  );
endinterface

// File: rtl/fpu_mmio_regs.sv
// rtl/fpu_mmio_regs.sv - FPU MMIO register window: operands, issue FSM, result/status capture
module fpu_mmio_regs #(
  parameter logic [12:0] BASE_ADDR     = 13'h0600,
  parameter int          FPU_LATENCY   = 4,
  parameter int          TIMEOUT_SLACK = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fpu_mmio_regs_if.slave        bus,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic [1:0]            fpu_op,
  output logic                  fpu_start,
  input  logic                  fpu_valid,
  input  logic [31:0]           fpu_result,
  input  logic [4:0]            fpu_flags,
  output logic                  busy,
  output logic                  irq
);

  localparam int          TO_CYCLES = FPU_LATENCY + TIMEOUT_SLACK;
  localparam int          CW        = $clog2(TO_CYCLES + 1);
  localparam logic [10:0] BASE_WORD = BASE_ADDR[12:2];

  localparam logic [2:0] OFF_A      = 3'd0;
  localparam logic [2:0] OFF_B      = 3'd1;
  localparam logic [2:0] OFF_CMD    = 3'd2;
  localparam logic [2:0] OFF_RESULT = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] result_q;
  logic [4:0]  flags_q;
  logic        done_q, error_q, overrun_q, irq_en_q;

  logic [10:0] word_off;
  logic [2:0]  off;
  logic        wr, rd;
  logic        wr_a, wr_b, wr_cmd, wr_ctrl, go_req;
  logic        rd_result, rd_status;
  logic        go_accept, capture, timeout;
  logic        unused_adr_lsb;

  // Word offset from the base; the window spans eight words, of which six are mapped.
  assign word_off       = bus.data_adr[12:2] - BASE_WORD;
  assign off            = word_off[2:0];
  assign bus.hit        = (word_off[10:3] == 8'd0);
  assign unused_adr_lsb = ^bus.data_adr[1:0];

  assign wr        = bus.hit & bus.mem_write;
  assign rd        = bus.hit & ~bus.mem_write;
  assign wr_a      = wr & (off == OFF_A);
  assign wr_b      = wr & (off == OFF_B);
  assign wr_cmd    = wr & (off == OFF_CMD);
  assign wr_ctrl   = wr & (off == OFF_CTRL);
  assign go_req    = wr_cmd & bus.write_data[0];
  assign rd_result = rd & (off == OFF_RESULT);
  assign rd_status = rd & (off == OFF_STATUS);

  assign busy      = (state_q != S_IDLE);
  assign fpu_start = (state_q == S_ISSUE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_accept = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_req) begin
          go_accept = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(TO_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid strobe on the last counted cycle still wins over the timeout.
        if (fpu_valid) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q <= CW'(1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      // Operands are frozen while an operation is in flight.
      if (wr_a && !busy) fpu_a <= bus.write_data;
      if (wr_b && !busy) fpu_b <= bus.write_data;
      if (go_accept)     fpu_op <= bus.write_data[2:1];
      if (wr_ctrl)       irq_en_q <= bus.write_data[0];

      if (capture) begin
        result_q <= fpu_result;
        flags_q  <= fpu_flags;
      end else if (go_accept) begin
        flags_q  <= '0;
      end

      if (capture)                done_q <= 1'b1;
      else if (go_accept)         done_q <= 1'b0;
      else if (rd_result)         done_q <= 1'b0;

      if (timeout)                error_q <= 1'b1;
      else if (go_accept)         error_q <= 1'b0;

      if ((wr_a || wr_b || go_req) && busy) overrun_q <= 1'b1;
      else if (go_accept || rd_status)      overrun_q <= 1'b0;

      irq <= done_q & irq_en_q;
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.hit) begin
      case (off)
        OFF_A:      bus.read_data = fpu_a;
        OFF_B:      bus.read_data = fpu_b;
        OFF_RESULT: bus.read_data = result_q;
        OFF_STATUS: bus.read_data = {23'd0, flags_q, overrun_q, error_q, done_q, busy};
        OFF_CTRL:   bus.read_data = {31'd0, irq_en_q};
        default:    bus.read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mmio_regs.sv
// tb/tb_fpu_mmio_regs.sv - self-checking bench for fpu_mmio_regs with an FPU responder
module tb_fpu_mmio_regs;
  localparam logic [12:0] BASE     = 13'h0600;
  localparam logic [12:0] IDLE_ADR = 13'h0000;
  localparam logic [12:0] A_ADR    = BASE + 13'h00;
  localparam logic [12:0] B_ADR    = BASE + 13'h04;
  localparam logic [12:0] CMD_ADR  = BASE + 13'h08;
  localparam logic [12:0] RES_ADR  = BASE + 13'h0C;
  localparam logic [12:0] STA_ADR  = BASE + 13'h10;
  localparam logic [12:0] CTL_ADR  = BASE + 13'h14;
  localparam int          LAT      = 4;
  localparam int          SLACK    = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_valid, busy, irq;
  logic [4:0]  fpu_flags;

  always #5 clk = ~clk;

  fpu_mmio_regs_if bus ();

  fpu_mmio_regs #(.BASE_ADDR(BASE), .FPU_LATENCY(LAT), .TIMEOUT_SLACK(SLACK)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_valid(fpu_valid), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .busy(busy), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the architectural register state.
  logic [31:0] m_a, m_b, m_result;
  logic [4:0]  m_flags;
  logic        m_done, m_err, m_ovr, m_irq_en;

  int          start_count = 0;
  int          model_delay = 0;
  logic [31:0] model_result = '0;
  logic [4:0]  model_flags = '0;
  logic [31:0] cap_a, cap_b;
  logic [1:0]  cap_op;

  always @(negedge clk) if (fpu_start === 1'b1) start_count++;

  // FPU model: answers each start pulse after model_delay cycles, or never when 0.
  initial begin
    fpu_valid = 1'b0;
    fpu_result = '0;
    fpu_flags = '0;
    forever begin
      @(negedge clk);
      if (fpu_start === 1'b1) begin
        cap_a = fpu_a;
        cap_b = fpu_b;
        cap_op = fpu_op;
        if (model_delay > 0) begin
          repeat (model_delay) @(posedge clk);
          #1;
          fpu_valid = 1'b1;
          fpu_result = model_result;
          fpu_flags = model_flags;
          @(posedge clk);
          #1;
          fpu_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(input logic b);
    return {23'd0, m_flags, m_ovr, m_err, m_done, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [12:0] adr, input logic [31:0] d);
    bus.mem_write = 1'b1;
    bus.data_adr = adr;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    bus.data_adr = IDLE_ADR;
    bus.write_data = '0;
  endtask

  task automatic rd_chk(input logic [12:0] adr, input string tag, input logic [31:0] exp);
    logic [12:0] off;
    bus.mem_write = 1'b0;
    bus.data_adr = adr;
    @(negedge clk);
    chk(tag, bus.read_data, exp);
    @(posedge clk);
    #1;
    bus.data_adr = IDLE_ADR;
    off = (adr - BASE) >> 2;
    if (off == 13'd4) m_ovr = 1'b0;
    if (off == 13'd3) m_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL %s: busy still high after %0d cycles, required low", tag, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_go();
    m_done = 1'b0;
    m_err = 1'b0;
    m_flags = '0;
    m_ovr = 1'b0;
  endtask

  task automatic go_op(input logic [12:0] adr, input logic [1:0] op, input logic [31:0] res,
                       input logic [4:0] flg, input int delay, input string tag);
    int s0;
    model_delay = delay;
    model_result = res;
    model_flags = flg;
    s0 = start_count;
    wr(adr, {29'd0, op, 1'b1});
    model_go();
    wait_idle({tag, "_idle"});
    chk({tag, "_starts"}, start_count - s0, 1);
    chk({tag, "_fpu_a"}, cap_a, m_a);
    chk({tag, "_fpu_b"}, cap_b, m_b);
    chk({tag, "_fpu_op"}, 32'(cap_op), 32'(op));
    if (delay > 0) begin
      m_result = res;
      m_flags = flg;
      m_done = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_result = '0; m_flags = '0;
    m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_irq_en = 1'b0;
  endtask

  initial begin
    int s0;
    logic [31:0] ra, rb, rres;
    logic [4:0]  rflg;
    logic [1:0]  rop;
    logic [12:0] lsb;

    reset_n = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_adr = IDLE_ADR;
    bus.write_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_start", 32'(fpu_start), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk(A_ADR, "reset_a", 0);
    rd_chk(B_ADR, "reset_b", 0);
    rd_chk(RES_ADR, "reset_result", 0);
    rd_chk(STA_ADR, "reset_status", 0);
    rd_chk(CTL_ADR, "reset_ctrl", 0);

    // Nominal add: 10.0 + 20.0 = 30.0
    wr(A_ADR, 32'h4120_0000); m_a = 32'h4120_0000;
    wr(B_ADR, 32'h41A0_0000); m_b = 32'h41A0_0000;
    go_op(CMD_ADR, 2'd0, 32'h41F0_0000, 5'd0, 4, "add");
    chk("add_busy", 32'(busy), 0);
    rd_chk(STA_ADR, "add_status", 32'h2);
    rd_chk(RES_ADR, "add_result", 32'h41F0_0000);
    rd_chk(A_ADR, "add_a_readback", 32'h4120_0000);

    // Flags and interrupt
    wr(CTL_ADR, 32'h1); m_irq_en = 1'b1;
    rd_chk(CTL_ADR, "ctrl_readback", 32'h1);
    go_op(CMD_ADR, 2'd2, 32'h3F80_0000, 5'b01000, 3, "flag");
    rd_chk(STA_ADR, "flag_status", 32'h82);
    chk("flag_irq_high", 32'(irq), 1);
    rd_chk(RES_ADR, "flag_result", 32'h3F80_0000);
    @(posedge clk);
    #1;
    chk("flag_irq_low", 32'(irq), 0);
    rd_chk(STA_ADR, "flag_status_after_read", exp_status(1'b0));

    // Overrun: A write and second GO while busy
    wr(A_ADR, 32'h1111_1111); m_a = 32'h1111_1111;
    model_delay = 6;
    model_result = 32'h4000_0000;
    model_flags = 5'b00001;
    s0 = start_count;
    wr(CMD_ADR, 32'h3);
    model_go();
    wr(A_ADR, 32'h7);
    m_ovr = 1'b1;
    wr(CMD_ADR, 32'h5);
    wait_idle("ovr_idle");
    m_result = 32'h4000_0000; m_flags = 5'b00001; m_done = 1'b1;
    chk("ovr_starts", start_count - s0, 1);
    chk("ovr_fpu_a", cap_a, 32'h1111_1111);
    chk("ovr_fpu_op", 32'(cap_op), 1);
    rd_chk(A_ADR, "ovr_a_kept", 32'h1111_1111);
    rd_chk(STA_ADR, "ovr_status_set", exp_status(1'b0));
    rd_chk(STA_ADR, "ovr_status_cleared", exp_status(1'b0));
    rd_chk(RES_ADR, "ovr_result", 32'h4000_0000);

    // Timeout: the FPU never answers
    wr(CTL_ADR, 32'h0); m_irq_en = 1'b0;
    model_delay = 0;
    wr(CMD_ADR, 32'h1);
    model_go();
    repeat (LAT + SLACK) @(posedge clk);
    #1;
    chk("to_busy_before", 32'(busy), 1);
    @(posedge clk);
    #1;
    chk("to_busy_after", 32'(busy), 0);
    m_err = 1'b1;
    rd_chk(STA_ADR, "to_status", 32'h4);
    rd_chk(RES_ADR, "to_result_kept", m_result);
    model_delay = 2;
    model_result = 32'hC000_0000;
    model_flags = 5'd0;
    wr(CMD_ADR, 32'h1);
    model_go();
    rd_chk(STA_ADR, "to_error_cleared", exp_status(1'b1));
    wait_idle("to_retry_idle");
    m_result = 32'hC000_0000; m_done = 1'b1;
    rd_chk(STA_ADR, "to_retry_status", 32'h2);

    // Decode
    rd_chk(BASE + 13'h18, "dec_unmapped", 0);
    rd_chk(CMD_ADR, "dec_cmd_reads0", 0);
    bus.data_adr = 13'h0700;
    @(negedge clk);
    chk("dec_outside_hit", 32'(bus.hit), 0);
    chk("dec_outside_data", bus.read_data, 0);
    bus.data_adr = CTL_ADR;
    @(negedge clk);
    chk("dec_inside_hit", 32'(bus.hit), 1);
    @(posedge clk);
    #1;
    bus.data_adr = IDLE_ADR;
    wr(BASE + 13'h18, 32'hFFFF_FFFF);
    rd_chk(CTL_ADR, "dec_ctrl_untouched", 32'(m_irq_en));
    rd_chk(A_ADR + 13'h1, "dec_a_lsb_ignored", m_a);
    go_op(CMD_ADR + 13'h3, 2'd2, 32'h1234_5678, 5'b10000, 5, "dec_cmd_lsb");
    rd_chk(RES_ADR, "dec_cmd_lsb_result", 32'h1234_5678);

    // Randomized operations against the model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rres = $urandom;
      rflg = 5'($urandom_range(0, 31));
      rop = 2'($urandom_range(0, 3));
      lsb = 13'($urandom_range(0, 3));
      wr(A_ADR + lsb, ra); m_a = ra;
      wr(B_ADR + lsb, rb); m_b = rb;
      if ($urandom_range(0, 1) == 1) begin
        wr(CTL_ADR, 32'h1); m_irq_en = 1'b1;
      end else begin
        wr(CTL_ADR, 32'h0); m_irq_en = 1'b0;
      end
      go_op(CMD_ADR + lsb, rop, rres, rflg, $urandom_range(1, 10), "rnd");
      chk("rnd_irq", 32'(irq), 32'(m_done & m_irq_en));
      rd_chk(STA_ADR, "rnd_status", exp_status(1'b0));
      rd_chk(RES_ADR, "rnd_result", m_result);
      rd_chk(STA_ADR, "rnd_status_read", exp_status(1'b0));
    end

    // Reset in the middle of WAIT; the late valid must be ignored
    wr(A_ADR, 32'd10); m_a = 32'd10;
    wr(B_ADR, 32'd20); m_b = 32'd20;
    model_delay = 6;
    model_result = 32'hDEAD_BEEF;
    model_flags = 5'b11111;
    wr(CMD_ADR, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    bus.data_adr = RES_ADR;
    #1;
    chk("rst_busy_async", 32'(busy), 0);
    chk("rst_result_async", bus.read_data, 0);
    bus.data_adr = IDLE_ADR;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    model_reset();
    repeat (8) @(posedge clk);
    #1;
    rd_chk(RES_ADR, "rst_result_late_valid", 0);
    rd_chk(STA_ADR, "rst_status_late_valid", 0);
    rd_chk(A_ADR, "rst_a", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
